// File: rtl/flash_program_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : flash_program_sequencer
// Purpose : JEDEC program / sector-erase / reset sequencer using idle M2 flash cycles.
// Rev     : 1.0  initial release
// ============================================================================
module flash_program_sequencer #(
  parameter int          ADDR_W     = 27,
  parameter logic [11:0] UNLOCK1    = 12'hAAA,
  parameter logic [11:0] UNLOCK2    = 12'h555,
  parameter logic [19:0] POLL_LIMIT = 20'hFFFFF
) (
  input  logic              m2_i,
  input  logic              rst_n_i,
  input  logic              cmd_start_i,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [7:0]        cmd_data_i,
  input  logic              cpu_flash_req_i,
  input  logic [7:0]        flash_dq_in_i,
  output logic              seq_grant_o,
  output logic [ADDR_W-1:0] seq_addr_o,
  output logic [7:0]        seq_data_o,
  output logic              seq_we_n_o,
  output logic              seq_oe_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam logic [1:0] OP_PROG  = 2'b00;
  localparam logic [1:0] OP_ERASE = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_WR0     = 4'd1;
  localparam logic [3:0] S_WR1     = 4'd2;
  localparam logic [3:0] S_WR2     = 4'd3;
  localparam logic [3:0] S_WR3     = 4'd4;
  localparam logic [3:0] S_WR4     = 4'd5;
  localparam logic [3:0] S_WR5     = 4'd6;
  localparam logic [3:0] S_POLL    = 4'd7;
  localparam logic [3:0] S_RECHECK = 4'd8;
  localparam logic [3:0] S_ABORT   = 4'd9;
  localparam logic [3:0] S_FIN_OK  = 4'd10;
  localparam logic [3:0] S_FIN_ERR = 4'd11;

  logic [3:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [19:0]       cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic              is_write, is_read, step, is_last, target7, dq_match;
  logic [ADDR_W-1:0] u1_addr, u2_addr;
  logic              unused_dq;

  assign is_write = (state_q inside {S_WR0, S_WR1, S_WR2, S_WR3, S_WR4, S_WR5, S_ABORT});
  assign is_read  = (state_q == S_POLL) || (state_q == S_RECHECK);
  // CPU always wins: a requested CPU flash cycle freezes the sequencer for that cycle.
  assign step     = (is_write || is_read) && !cpu_flash_req_i;
  assign is_last  = ((state_q == S_WR0) && (op_q == OP_RESET)) ||
                    ((state_q == S_WR3) && (op_q == OP_PROG))  ||
                    (state_q == S_WR5);
  assign target7  = (op_q == OP_PROG) ? data_q[7] : 1'b1;
  assign dq_match = (flash_dq_in_i[7] == target7);
  assign u1_addr  = {addr_q[ADDR_W-1:12], UNLOCK1};
  assign u2_addr  = {addr_q[ADDR_W-1:12], UNLOCK2};
  assign unused_dq = ^{flash_dq_in_i[6], flash_dq_in_i[4:0]};

  always_ff @(posedge m2_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_start_i) begin
          op_d    = cmd_op_i;
          addr_d  = cmd_addr_i;
          data_d  = cmd_data_i;
          cnt_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = (cmd_op_i == OP_RSVD) ? S_FIN_ERR : S_WR0;
        end
      end
      S_WR0, S_WR1, S_WR2, S_WR3, S_WR4, S_WR5: begin
        if (step) begin
          if (is_last) state_d = (op_q == OP_RESET) ? S_FIN_OK : S_POLL;
          else         state_d = state_q + 4'd1;
        end
      end
      S_POLL: begin
        if (step) begin
          if (dq_match) begin
            state_d = S_FIN_OK;
          end else if (flash_dq_in_i[5]) begin
            state_d = S_RECHECK;
          end else begin
            cnt_d = cnt_q + 20'd1;
            if (cnt_d == POLL_LIMIT) state_d = S_ABORT;
          end
        end
      end
      S_RECHECK: if (step) state_d = dq_match ? S_FIN_OK : S_ABORT;
      S_ABORT:   if (step) state_d = S_FIN_ERR;
      S_FIN_OK, S_FIN_ERR: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (state_d == S_FIN_OK) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    if (state_d == S_FIN_ERR) begin
      busy_d  = 1'b0;
      error_d = 1'b1;
    end
  end

  always_comb begin
    seq_grant_o = step;
    seq_we_n_o  = !(step && is_write);
    seq_oe_n_o  = !(step && is_read);
    seq_addr_o  = '0;
    seq_data_o  = '0;
    if (step) begin
      case (state_q)
        S_WR0: begin
          seq_addr_o = (op_q == OP_RESET) ? addr_q : u1_addr;
          seq_data_o = (op_q == OP_RESET) ? 8'hF0 : 8'hAA;
        end
        S_WR1: begin seq_addr_o = u2_addr; seq_data_o = 8'h55; end
        S_WR2: begin seq_addr_o = u1_addr; seq_data_o = (op_q == OP_PROG) ? 8'hA0 : 8'h80; end
        S_WR3: begin
          seq_addr_o = (op_q == OP_PROG) ? addr_q : u1_addr;
          seq_data_o = (op_q == OP_PROG) ? data_q : 8'hAA;
        end
        S_WR4:   begin seq_addr_o = u2_addr; seq_data_o = 8'h55; end
        S_WR5:   begin seq_addr_o = addr_q;  seq_data_o = 8'h30; end
        S_ABORT: begin seq_addr_o = addr_q;  seq_data_o = 8'hF0; end
        default: seq_addr_o = addr_q;
      endcase
    end
    busy_o  = busy_q;
    done_o  = done_q;
    error_o = error_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_flash_program_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized bench for flash_program_sequencer against a command-level flash/sequence model.
module tb_flash_program_sequencer;
  localparam int AW = 27;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  logic          m2 = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_start = 1'b0;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_data = 8'h00;
  logic          cpu_req = 1'b0;
  logic [7:0]    flash_dq = 8'h00;
  logic          sel = 1'b0;

  logic          g0, we0, oe0, b0, dn0, er0, g8, we8, oe8, b8, dn8, er8;
  logic [AW-1:0] a0, a8;
  logic [7:0]    d0, d8;
  logic          grant, we_n, oe_n, busy, done, error;
  logic [AW-1:0] saddr;
  logic [7:0]    sdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 m2 = ~m2;

  flash_program_sequencer u_dut (
    .m2_i(m2), .rst_n_i(rst_n), .cmd_start_i(cmd_start), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cpu_flash_req_i(cpu_req),
    .flash_dq_in_i(flash_dq), .seq_grant_o(g0), .seq_addr_o(a0), .seq_data_o(d0),
    .seq_we_n_o(we0), .seq_oe_n_o(oe0), .busy_o(b0), .done_o(dn0), .error_o(er0)
  );

  flash_program_sequencer #(.POLL_LIMIT(20'd8)) u_dut_lim8 (
    .m2_i(m2), .rst_n_i(rst_n), .cmd_start_i(cmd_start), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cpu_flash_req_i(cpu_req),
    .flash_dq_in_i(flash_dq), .seq_grant_o(g8), .seq_addr_o(a8), .seq_data_o(d8),
    .seq_we_n_o(we8), .seq_oe_n_o(oe8), .busy_o(b8), .done_o(dn8), .error_o(er8)
  );

  assign grant = sel ? g8 : g0;
  assign we_n  = sel ? we8 : we0;
  assign oe_n  = sel ? oe8 : oe0;
  assign saddr = sel ? a8 : a0;
  assign sdata = sel ? d8 : d0;
  assign busy  = sel ? b8 : b0;
  assign done  = sel ? dn8 : dn0;
  assign error = sel ? er8 : er0;

  task automatic do_reset();
    cmd_start = 1'b0;
    cpu_req   = 1'b0;
    flash_dq  = 8'h00;
    @(negedge m2);
    rst_n = 1'b0;
    repeat (2) @(negedge m2);
    rst_n = 1'b1;
  endtask

  // Starts one command and follows it cycle by cycle; expectations come from the
  // command-level model (write list, poll outcome, stall-adjusted completion cycle).
  task automatic run_op(input logic [1:0] op, input logic [AW-1:0] addr, input logic [7:0] data,
                        input int nbusy, input bit d5, input bit lim8,
                        input logic [31:0] stall, input int pulse_c,
                        output int o_fin, output int o_nw, output int o_nr);
    wr_t           exp_w[$];
    wr_t           obs_w[$];
    logic [AW-1:0] u1, u2;
    logic [7:0]    noise;
    logic [31:0]   r;
    logic          t7;
    int            lim, exp_rd, n, fin, steps, rd, c;
    bit            ok, st;
    u1  = {addr[AW-1:12], 12'hAAA};
    u2  = {addr[AW-1:12], 12'h555};
    lim = lim8 ? 8 : 20'hFFFFF;
    t7  = (op == 2'b00) ? data[7] : 1'b1;
    exp_rd = 0;
    ok  = 1'b0;
    case (op)
      2'b00: begin
        exp_w.push_back({u1, 8'hAA}); exp_w.push_back({u2, 8'h55});
        exp_w.push_back({u1, 8'hA0}); exp_w.push_back({addr, data});
      end
      2'b01: begin
        exp_w.push_back({u1, 8'hAA}); exp_w.push_back({u2, 8'h55});
        exp_w.push_back({u1, 8'h80}); exp_w.push_back({u1, 8'hAA});
        exp_w.push_back({u2, 8'h55}); exp_w.push_back({addr, 8'h30});
      end
      2'b10: begin exp_w.push_back({addr, 8'hF0}); ok = 1'b1; end
      default: ok = 1'b0;
    endcase
    if (op == 2'b00 || op == 2'b01) begin
      if (nbusy == 0)       begin exp_rd = 1;     ok = 1'b1; end
      else if (d5)          begin exp_rd = 2;     ok = (nbusy == 1); end
      else if (nbusy < lim) begin exp_rd = nbusy + 1; ok = 1'b1; end
      else                  begin exp_rd = lim;   ok = 1'b0; end
      if (!ok) exp_w.push_back({addr, 8'hF0});
    end
    n = exp_w.size() + exp_rd;
    c = 1;
    steps = 0;
    while (steps < n) begin
      st = (c <= 32) ? stall[c-1] : 1'b0;
      if (!st) steps++;
      c++;
    end
    fin = c;

    sel   = lim8;
    r     = $urandom;
    noise = r[7:0];
    @(negedge m2);
    cmd_start = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cpu_req = 1'b0;
    @(posedge m2);
    #1;
    rd = 0;
    o_fin = 0;
    for (int cy = 1; cy <= fin + 1; cy++) begin
      cpu_req   = (cy <= 32) ? stall[cy-1] : 1'b0;
      cmd_start = (cy == pulse_c);
      r = $urandom;
      cmd_op = r[1:0]; cmd_data = r[9:2];
      r = $urandom;
      cmd_addr = r[AW-1:0];
      #2;
      vectors++;
      if (grant !== ((cy < fin) && !cpu_req)) begin
        miscompares++;
        $display("FAIL grant c%0d: got %b want %b", cy, grant, (cy < fin) && !cpu_req);
      end
      vectors++;
      if ({we_n, oe_n} !== (grant ? {we_n, ~we_n} : 2'b11)) begin
        miscompares++;
        $display("FAIL strobes c%0d: got we_n=%b oe_n=%b grant=%b", cy, we_n, oe_n, grant);
      end
      vectors++;
      if (busy !== (cy < fin && op != 2'b11)) begin
        miscompares++;
        $display("FAIL busy c%0d: got %b want %b", cy, busy, cy < fin && op != 2'b11);
      end
      vectors++;
      if ({done, error} !== ((cy >= fin) ? {ok, !ok} : 2'b00)) begin
        miscompares++;
        $display("FAIL done_err c%0d: got %b%b want %b%b", cy, done, error,
                 (cy >= fin) && ok, (cy >= fin) && !ok);
      end
      if (o_fin == 0 && (done === 1'b1 || error === 1'b1)) o_fin = cy;
      if (grant === 1'b1 && we_n === 1'b0) obs_w.push_back({saddr, sdata});
      if (grant === 1'b1 && oe_n === 1'b0) begin
        vectors++;
        if (saddr !== addr) begin
          miscompares++;
          $display("FAIL read_addr c%0d: got %h want %h", cy, saddr, addr);
        end
        flash_dq = (rd < nbusy) ? {~t7, noise[6], d5, noise[4:0]} : {t7, noise[6:0]};
        rd++;
      end
      @(posedge m2);
      #1;
    end
    cpu_req   = 1'b0;
    cmd_start = 1'b0;
    o_nw = obs_w.size();
    o_nr = rd;
    vectors++;
    if (rd != exp_rd) begin
      miscompares++;
      $display("FAIL read_count: got %0d want %0d", rd, exp_rd);
    end
    vectors++;
    if (obs_w.size() != exp_w.size()) begin
      miscompares++;
      $display("FAIL write_count: got %0d want %0d", obs_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      vectors++;
      if (obs_w[i] !== exp_w[i]) begin
        miscompares++;
        $display("FAIL write%0d: got %h/%h want %h/%h", i, obs_w[i].a, obs_w[i].d,
                 exp_w[i].a, exp_w[i].d);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({grant, we_n, oe_n, saddr, sdata, busy, done, error} !== {3'b011, 27'h0, 8'h00, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_values: got g%b we%b oe%b a%h d%h b%b dn%b e%b", grant, we_n, oe_n,
               saddr, sdata, busy, done, error);
    end
    do_reset();
  endtask

  task automatic test_program();
    int fin, nw, nr;
    do_reset();
    run_op(2'b00, 27'h12345, 8'h5A, 0, 1'b0, 1'b0, 32'h0, 0, fin, nw, nr);
    vectors++;
    if (fin != 6) begin miscompares++; $display("FAIL prog_latency: got %0d want 6", fin); end
  endtask

  task automatic test_program_stall();
    int fin, nw, nr;
    do_reset();
    run_op(2'b00, 27'h12345, 8'h5A, 0, 1'b0, 1'b0, 32'h6, 0, fin, nw, nr);
    vectors++;
    if (fin != 8) begin miscompares++; $display("FAIL stall_latency: got %0d want 8", fin); end
  endtask

  task automatic test_erase();
    int fin, nw, nr;
    do_reset();
    run_op(2'b01, 27'h40000, 8'h00, 10, 1'b0, 1'b0, 32'h0, 0, fin, nw, nr);
    vectors++;
    if ({nw, nr} != {32'd6, 32'd11}) begin
      miscompares++;
      $display("FAIL erase_counts: got %0d/%0d want 6/11", nw, nr);
    end
  endtask

  task automatic test_recheck_abort();
    int fin, nw, nr;
    do_reset();
    run_op(2'b00, 27'h0ABCD, 8'hC3, 2, 1'b1, 1'b0, 32'h0, 0, fin, nw, nr);
    vectors++;
    if ({nw, nr} != {32'd5, 32'd2}) begin
      miscompares++;
      $display("FAIL recheck_counts: got %0d/%0d want 5/2", nw, nr);
    end
  endtask

  task automatic test_poll_limit();
    int fin, nw, nr;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      run_op(2'b00, 27'h7F00F, 8'h11, 1000, 1'b0, 1'b1, 32'h0, 7, fin, nw, nr);
      vectors++;
      if ({nw, nr} != {32'd5, 32'd8}) begin
        miscompares++;
        $display("FAIL limit_counts run%0d: got %0d/%0d want 5/8", k, nw, nr);
      end
    end
  endtask

  task automatic test_reserved_op();
    int fin, nw, nr;
    do_reset();
    run_op(2'b11, 27'h1234, 8'h99, 0, 1'b0, 1'b0, 32'h0, 0, fin, nw, nr);
    vectors++;
    if (fin != 1) begin miscompares++; $display("FAIL rsvd_latency: got %0d want 1", fin); end
  endtask

  task automatic test_reset_midop();
    int fin, nw, nr;
    do_reset();
    sel = 1'b0;
    @(negedge m2);
    cmd_start = 1'b1; cmd_op = 2'b00; cmd_addr = 27'h3456; cmd_data = 8'h77;
    @(posedge m2); #1; cmd_start = 1'b0;
    @(posedge m2); #1;
    @(posedge m2); #2;
    vectors++;
    if ({grant, we_n, saddr, sdata} !== {2'b10, 27'h3AAA, 8'hA0}) begin
      miscompares++;
      $display("FAIL midop_wr2: got g%b we%b %h/%h want 10 3aaa/a0", grant, we_n, saddr, sdata);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({grant, we_n, oe_n, saddr, sdata, busy, done, error} !== {3'b011, 27'h0, 8'h00, 3'b000}) begin
      miscompares++;
      $display("FAIL midop_async_reset: got g%b we%b oe%b a%h d%h b%b", grant, we_n, oe_n,
               saddr, sdata, busy);
    end
    @(negedge m2);
    rst_n = 1'b1;
    run_op(2'b10, 27'h3456, 8'h00, 0, 1'b0, 1'b0, 32'h0, 0, fin, nw, nr);
    vectors++;
    if ({fin, nw} != {32'd2, 32'd1}) begin
      miscompares++;
      $display("FAIL reset_op: got fin %0d writes %0d want 2/1", fin, nw);
    end
  endtask

  task automatic test_random();
    int fin, nw, nr;
    logic [31:0] ra, rs;
    for (int it = 0; it < 24; it++) begin
      do_reset();
      ra = $urandom;
      rs = $urandom & $urandom;
      run_op(2'($urandom_range(0, 3)), ra[AW-1:0], 8'($urandom), int'($urandom_range(0, 12)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rs,
             int'($urandom_range(0, 1)), fin, nw, nr);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_program();
    test_program_stall();
    test_erase();
    test_recheck_abort();
    test_poll_limit();
    test_reserved_op();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
